// File: rtl/alu_pkg.sv
// Shared ALU command encoding and multiplier FSM state type.
// Used by the sequential multiplier and by the ALU it shares.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_GT  = 3'b011,
    ALU_SRL = 3'b100,
    ALU_AND = 3'b101,
    ALU_OR  = 3'b110,
    ALU_EQ  = 3'b111
  } alu_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SLL  = 3'd2,
    ST_SRL  = 3'd3,
    ST_DONE = 3'd4
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 16x16->16 multiplier sequenced over an external shared ALU.
// Fixed latency 3*ITERS+1 cycles from accepted start to done; abort returns to IDLE.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int ITERS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [2:0]  alu_cmd,
  input  logic [15:0] alu_res,
  input  logic        alu_ovf
);

  localparam int IW = (ITERS > 1) ? $clog2(ITERS) : 1;

  mul_state_t    state, next_state;
  alu_cmd_t      cmd;
  logic [15:0]   acc, mcand, mplier;
  logic [IW-1:0] iter;
  logic          last_iter;
  logic          accept;

  assign last_iter = (iter == IW'(ITERS - 1));
  assign accept    = start && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_ADD;
      ST_ADD:  next_state = ST_SLL;
      ST_SLL:  next_state = ST_SRL;
      ST_SRL:  next_state = last_iter ? ST_DONE : ST_ADD;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
    // Abort overrides every in-flight transition.
    if (abort && state != ST_IDLE) begin
      next_state = ST_IDLE;
    end
  end

  always_comb begin
    cmd     = ALU_ADD;
    alu_op1 = 16'd0;
    alu_op2 = 16'd0;
    case (state)
      ST_ADD: begin
        alu_op1 = acc;
        alu_op2 = mcand;
      end
      ST_SLL: begin
        cmd     = ALU_SLL;
        alu_op1 = mcand;
        alu_op2 = 16'd1;
      end
      ST_SRL: begin
        cmd     = ALU_SRL;
        alu_op1 = mplier;
        alu_op2 = 16'd1;
      end
      default: ;
    endcase
  end

  assign alu_cmd = cmd;
  assign busy    = (state != ST_IDLE);

  // product and done are loaded on entry to DONE so both appear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= 16'd0;
      mcand   <= 16'd0;
      mplier  <= 16'd0;
      iter    <= '0;
      product <= 16'd0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != ST_IDLE) begin
        ovf <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              acc    <= 16'd0;
              mcand  <= op_a;
              mplier <= op_b;
              iter   <= '0;
              ovf    <= 1'b0;
            end
          end
          ST_ADD: begin
            if (mplier[0]) begin
              acc <= alu_res;
              ovf <= ovf | alu_ovf;
            end
          end
          ST_SLL: mcand <= alu_res;
          ST_SRL: begin
            mplier <= alu_res;
            iter   <= iter + IW'(1);
            if (last_iter) begin
              done    <= 1'b1;
              product <= acc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural shared ALU.
module tb_alu_mul_seq;

  logic        clk, rst, start, abort;
  logic [15:0] op_a, op_b;
  logic        busy, done, ovf;
  logic [15:0] product;
  logic [15:0] alu_op1, alu_op2, alu_res;
  logic [2:0]  alu_cmd;
  logic        alu_ovf;

  int total = 0;
  int bad   = 0;

  alu_mul_seq #(.ITERS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .product(product), .ovf(ovf),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd),
    .alu_res(alu_res), .alu_ovf(alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU behaviour
  always_comb begin
    alu_res = 16'd0;
    alu_ovf = 1'b0;
    case (alu_cmd)
      3'b000: begin
        alu_res = alu_op1 + alu_op2;
        alu_ovf = (alu_op1[15] == alu_op2[15]) && (alu_res[15] != alu_op1[15]);
      end
      3'b001: begin
        alu_res = alu_op1 - alu_op2;
        alu_ovf = (alu_op1[15] != alu_op2[15]) && (alu_res[15] != alu_op1[15]);
      end
      3'b010: alu_res = alu_op1 << alu_op2[3:0];
      3'b100: alu_res = alu_op1 >> alu_op2[3:0];
      3'b011: alu_res = {15'd0, alu_op1 > alu_op2};
      3'b111: alu_res = {15'd0, alu_op1 == alu_op2};
      3'b101: alu_res = alu_op1 & alu_op2;
      3'b110: alu_res = alu_op1 | alu_op2;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: product is the wrapped arithmetic product; ovf is any signed
  // overflow among the partial-product additions a<<i for set bits b[i].
  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] p, output logic o);
    logic [31:0] full;
    logic [15:0] acc, term, sum;
    full = {16'd0, a} * {16'd0, b};
    p    = full[15:0];
    acc  = 16'd0;
    o    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        term = a << i;
        sum  = acc + term;
        if (acc[15] == term[15] && sum[15] != acc[15]) o = 1'b1;
        acc = sum;
      end
    end
  endfunction

  // Caller is at a negedge. Start is seen at edge N; cycle k is the k-th
  // negedge after N. s2/ab inject a second start or an abort in cycle k.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input int s2, input int ab,
                       output logic [15:0] p, output logic o,
                       output int ndone, output int first_done, output int busy_err);
    logic exp_busy;
    ndone = 0; first_done = -1; busy_err = 0;
    op_a = a; op_b = b; start = 1'b1; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = ~a; op_b = ~b;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      exp_busy = (ab > 0) ? (k <= ab) : (k <= 49);
      if (busy !== exp_busy) busy_err++;
      start = (k == s2);
      abort = (k == ab);
      if (k == s2) begin
        op_a = 16'd100; op_b = 16'd200;
      end
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0;
    p = product; o = ovf;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_p;
    logic        exp_o;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [15:0] p, rp;
    logic o, ro;
    int nd, fd, be;

    vecs[0] = '{16'd3,      16'd5,      16'd15,     1'b0};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   16'h0001,   1'b1};
    vecs[2] = '{16'h3000,   16'd3,      16'h9000,   1'b1};
    vecs[3] = '{16'd1,      16'd1,      16'd1,      1'b0};
    vecs[4] = '{16'h8000,   16'd1,      16'h8000,   1'b0};
    vecs[5] = '{16'd2,      16'h8000,   16'd0,      1'b0};
    vecs[6] = '{16'h7FFF,   16'd2,      16'hFFFE,   1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; op_a = 16'd0; op_b = 16'd0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);
    chk("reset_ovf", {31'd0, ovf}, 32'd0);
    chk("idle_alu_bus", {13'd0, alu_cmd, alu_op1 | alu_op2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, 0, p, o, nd, fd, be);
      chk($sformatf("tbl%0d_product", i), {16'd0, p}, {16'd0, vecs[i].exp_p});
      chk($sformatf("tbl%0d_ovf", i), {31'd0, o}, {31'd0, vecs[i].exp_o});
      chk($sformatf("tbl%0d_done_cycle", i), fd, 49);
      chk($sformatf("tbl%0d_done_count", i), nd, 1);
      chk($sformatf("tbl%0d_busy_cycles", i), be, 0);
    end

    // Second start mid-operation must be ignored
    do_op(16'd7, 16'd9, 10, 0, p, o, nd, fd, be);
    chk("s2_product", {16'd0, p}, 32'd63);
    chk("s2_done_count", nd, 1);
    chk("s2_done_cycle", fd, 49);
    chk("s2_busy_cycles", be, 0);

    // Abort after ovf has already been set; product must stay 63
    do_op(16'h3000, 16'd3, 0, 20, p, o, nd, fd, be);
    chk("abort_done_count", nd, 0);
    chk("abort_product", {16'd0, p}, 32'd63);
    chk("abort_ovf", {31'd0, o}, 32'd0);
    chk("abort_busy_cycles", be, 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; op_a = 16'd5; op_b = 16'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_abort_busy2", {31'd0, busy}, 32'd0);

    // Randomized against the reference model
    for (int i = 0; i < 20; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i < 4) rb = rb | 16'h8000;
      ref_mul(ra, rb, rp, ro);
      do_op(ra, rb, 0, 0, p, o, nd, fd, be);
      chk($sformatf("rnd%0d_product a=%0h b=%0h", i, ra, rb), {16'd0, p}, {16'd0, rp});
      chk($sformatf("rnd%0d_ovf a=%0h b=%0h", i, ra, rb), {31'd0, o}, {31'd0, ro});
      chk($sformatf("rnd%0d_done_cycle", i), fd, 49);
    end

    // Reset mid-operation: all outputs clear asynchronously
    op_a = 16'h1234; op_b = 16'h00FF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_product", {16'd0, product}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_alu_bus", {13'd0, alu_cmd, alu_op1 | alu_op2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(16'd3, 16'd5, 0, 0, p, o, nd, fd, be);
    chk("post_rst_product", {16'd0, p}, 32'd15);
    chk("post_rst_done_cycle", fd, 49);
    chk("post_rst_done_count", nd, 1);
    chk("post_rst_busy_cycles", be, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter: ITERS, 16, number of shift-add iterations (one per multiplier bit).
REQ-002 SHALL have port: clk  in  1  system clock, rising-edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  in  1  request a multiply, sampled only in IDLE.
REQ-005 SHALL have port: abort  in  1  cancel the operation in flight.
REQ-006 SHALL have port: op_a  in  16  multiplicand.
REQ-007 SHALL have port: op_b  in  16  multiplier.
REQ-008 SHALL have port: busy  out  1  high while not in IDLE.
REQ-009 SHALL have port: done  out  1  single-cycle completion pulse.
REQ-010 SHALL have port: product  out  16  low 16 bits of op_a*op_b, held until next accepted start.
REQ-011 SHALL have port: ovf  out  1  sticky signed-add overflow of the last operation.
REQ-012 SHALL have ports: alu_op1 out 16, alu_op2 out 16, alu_cmd out 3 (to the shared ALU); alu_res in 16, alu_ovf in 1 (from the ALU, combinational).

Function
REQ-013 SHALL use the ALU command encoding 000 add, 001 sub, 010 sll, 100 srl, 011 gt, 111 eq, 101 and, 110 or.
REQ-014 SHALL implement FSM states IDLE, ADD, SLL, SRL, DONE.
REQ-015 SHALL, in IDLE with start=1 and abort=0, latch acc=0, mcand=op_a, mplier=op_b, iter=0, clear ovf, and go to ADD.
REQ-016 SHALL, in ADD, drive alu_cmd=add, alu_op1=acc, alu_op2=mcand; if mplier[0]=1, SHALL load acc<=alu_res and OR alu_ovf into ovf; otherwise acc and ovf are unchanged; next state SLL.
REQ-017 SHALL, in SLL, drive alu_cmd=sll, alu_op1=mcand, alu_op2=1; load mcand<=alu_res; next state SRL.
REQ-018 SHALL, in SRL, drive alu_cmd=srl, alu_op1=mplier, alu_op2=1; load mplier<=alu_res and increment iter; next state DONE if iter=ITERS-1, else ADD.
REQ-019 SHALL, in DONE, assert done=1 for exactly one cycle, load product<=acc, and return to IDLE.
REQ-020 SHALL have a fixed latency: start accepted at edge N, done high during cycle N+3*ITERS+1 (N+49 at ITERS=16); there is no early exit.
REQ-021 SHALL drive alu_cmd=add, alu_op1=0, alu_op2=0 in IDLE and DONE.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, when abort=1 in any non-IDLE state, go to IDLE at the next edge with no done pulse, product unchanged, and ovf cleared.
REQ-024 SHALL give abort priority when start=1 and abort=1 together in IDLE: the start is not accepted.
REQ-025 SHALL wrap all arithmetic at 16 bits; bits shifted out of mcand are discarded; the result equals (op_a*op_b) mod 2^16 for both signed and unsigned interpretation.
REQ-026 SHALL drive busy combinationally from state (busy = state != IDLE); done and product are registered.

Reset
REQ-027 SHALL, on rst=1 (asynchronous, including mid-operation), enter IDLE and clear acc, mcand, mplier, iter, product, ovf and done to 0.
REQ-028 SHALL accept a start on the first rising edge after rst deasserts.

Structure
REQ-029 SHALL take the ALU command constants and the FSM state enum from shared package alu_pkg.
REQ-030 SHALL have no sub-module; the ALU is instantiated by the parent and connected through the alu_* ports.

Verification
REQ-031 Verification SHALL cover: op_a=3, op_b=5, start at edge N -> done during N+49 only, product=15, ovf=0, busy high during N+1..N+49.
REQ-032 Verification SHALL cover: op_a=0xFFFF, op_b=0xFFFF -> product=0x0001 (wrap-around).
REQ-033 Verification SHALL cover: op_a=0x3000, op_b=3 -> product=0x9000, ovf=1.
REQ-034 Verification SHALL cover: start with op_a=7, op_b=9, then a second start pulse with other operands at cycle 10 -> product=63, second start ignored, single done.
REQ-035 Verification SHALL cover: abort at cycle 20 of an operation -> IDLE next cycle, no done, product keeps its previous value; start and abort together in IDLE -> busy stays 0.
REQ-036 Verification SHALL cover: rst asserted mid-operation -> all outputs 0 immediately; a new start after release gives correct product and latency.
